// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 32-entry integer register file: merges ALU and
// load-return results onto the single write port and tracks pending writes.
module regfile_wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      Rs1,
  input  logic [4:0]      Rs2,
  output logic            Rs1Busy,
  output logic            Rs2Busy,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            WriteEn,
  output logic [4:0]      RsW,
  output logic [XLEN-1:0] WData
);

  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic [4:0]       lq_rd   [LQ_DEPTH];
  logic [XLEN-1:0]  lq_data [LQ_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [SW-1:0]    starve;
  logic [SW-1:0]    starve_next;

  logic             lq_empty;
  logic             lq_full;
  logic             force_ld;
  logic             push;
  logic             pop;
  logic             alu_acc;
  logic             wb_fire;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;

  assign lq_empty = (count == '0);
  assign lq_full  = (count == FULL_COUNT);
  assign force_ld = !lq_empty && (starve == STARVE_LIM);

  assign ld_ready  = !lq_full;
  assign alu_ready = !force_ld;

  assign push    = ld_valid && !lq_full;
  assign pop     = !lq_empty && (!alu_valid || force_ld);
  assign alu_acc = alu_valid && !force_ld;

  assign issue_ready = !busy[issue_rd] || (issue_rd == 5'd0);
  assign Rs1Busy     = busy[Rs1] && (Rs1 != 5'd0);
  assign Rs2Busy     = busy[Rs2] && (Rs2 != 5'd0);

  // A pop and an ALU acceptance are mutually exclusive, so the mux needs no priority beyond pop.
  always_comb begin
    wb_fire = pop || alu_acc;
    wb_rd   = alu_rd;
    wb_data = alu_data;
    if (pop) begin
      wb_rd   = lq_rd[rd_ptr];
      wb_data = lq_data[rd_ptr];
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    starve_next = '0;
    if (!lq_empty && !pop) begin
      starve_next = (starve == STARVE_LIM) ? starve : starve + SW'(1);
    end
  end

  // Clear is applied first so that a same-edge issue to the committing register keeps it busy.
  always_comb begin
    busy_next = busy;
    if (WriteEn) begin
      busy_next[RsW] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[wr_ptr]   <= ld_rd;
      lq_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
      busy   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count  <= count_next;
      starve <= starve_next;
      busy   <= busy_next;
    end
  end

  // x0 results are consumed without touching the write port, so RsW/WData keep the last real write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteEn <= 1'b0;
      RsW     <= 5'd0;
      WData   <= '0;
    end else begin
      WriteEn <= wb_fire && (wb_rd != 5'd0);
      if (wb_fire && (wb_rd != 5'd0)) begin
        RsW   <= wb_rd;
        WData <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized
// traffic compared against a queue/array reference model.
module tb_regfile_wb_ctrl;

  localparam int XLEN       = 32;
  localparam int LQ_DEPTH   = 4;
  localparam int STARVE_MAX = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  logic [4:0]      Rs1;
  logic [4:0]      Rs2;
  logic            Rs1Busy;
  logic            Rs2Busy;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            WriteEn;
  logic [4:0]      RsW;
  logic [XLEN-1:0] WData;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.XLEN(XLEN), .LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .Rs1(Rs1), .Rs2(Rs2), .Rs1Busy(Rs1Busy), .Rs2Busy(Rs2Busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .WriteEn(WriteEn), .RsW(RsW), .WData(WData)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ld_t;

  // Reference model state
  ld_t             m_q[$];
  bit              m_busy[32];
  int              m_starve;
  logic            m_we;
  logic [4:0]      m_rsw;
  logic [XLEN-1:0] m_wdata;
  logic e_issue_ready, e_alu_ready, e_ld_ready, e_rs1busy, e_rs2busy, e_pop;
  logic t_issue_acc, t_alu_acc, t_ld_acc;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_starve = 0;
    m_we = 1'b0;
    m_rsw = '0;
    m_wdata = '0;
    t_issue_acc = 1'b0;
    t_alu_acc = 1'b0;
    t_ld_acc = 1'b0;
  endtask

  task automatic model_comb();
    e_ld_ready    = (m_q.size() < LQ_DEPTH);
    e_alu_ready   = !((m_q.size() != 0) && (m_starve == STARVE_MAX));
    e_pop         = (m_q.size() != 0) && (!alu_valid || !e_alu_ready);
    e_issue_ready = (issue_rd == 5'd0) || !m_busy[issue_rd];
    e_rs1busy     = (Rs1 != 5'd0) && m_busy[Rs1];
    e_rs2busy     = (Rs2 != 5'd0) && m_busy[Rs2];
  endtask

  // Advance one clock and update the model with whatever handshakes happened on that edge.
  task automatic tick();
    ld_t             h;
    logic            fire;
    logic [4:0]      wrd;
    logic [XLEN-1:0] wd;
    int              qsz;
    model_comb();
    @(posedge clk);
    qsz  = m_q.size();
    fire = 1'b0;
    wrd  = '0;
    wd   = '0;
    t_issue_acc = issue_valid && e_issue_ready;
    t_alu_acc   = alu_valid && e_alu_ready;
    t_ld_acc    = ld_valid && e_ld_ready;
    if (e_pop) begin
      h = m_q.pop_front();
      fire = 1'b1; wrd = h.rd; wd = h.data;
    end else if (t_alu_acc) begin
      fire = 1'b1; wrd = alu_rd; wd = alu_data;
    end
    if (m_we) m_busy[m_rsw] = 1'b0;
    if (t_issue_acc && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    if (qsz != 0 && !e_pop) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else m_starve = 0;
    m_we = fire && (wrd != 5'd0);
    if (m_we) begin
      m_rsw = wrd;
      m_wdata = wd;
    end
    if (t_ld_acc) begin
      h.rd = ld_rd;
      h.data = ld_data;
      m_q.push_back(h);
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    Rs1 = '0; Rs2 = '0;
  endtask

  task automatic test_reset();
    issue_rd = 5'd1; Rs1 = 5'd1;
    #3;
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", WriteEn); end
    checks++; if (RsW !== 5'd0) begin errors++; $display("[TB] FAIL reset_rsw: got %0d want 0", RsW); end
    checks++; if (WData !== '0) begin errors++; $display("[TB] FAIL reset_wdata: got %h want 0", WData); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ld_ready: got %b want 1", ld_ready); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alu_ready: got %b want 1", alu_ready); end
    checks++; if (Rs1Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs1busy: got %b want 0", Rs1Busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready: got %b want 1", issue_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle();
  endtask

  task automatic test_alu_path();
    issue_valid = 1'b1; issue_rd = 5'd5; Rs1 = 5'd5;
    #2;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_issue_ready: got %b want 1", issue_ready); end
    checks++; if (Rs1Busy !== 1'b0) begin errors++; $display("[TB] FAIL alu_rs1busy_pre: got %b want 0", Rs1Busy); end
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #2;
    checks++; if (Rs1Busy !== 1'b1) begin errors++; $display("[TB] FAIL alu_rs1busy_issued: got %b want 1", Rs1Busy); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready: got %b want 1", alu_ready); end
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("[TB] FAIL alu_we_early: got %b want 0", WriteEn); end
    tick();
    alu_valid = 1'b0;
    #2;
    checks++; if (WriteEn !== 1'b1) begin errors++; $display("[TB] FAIL alu_we: got %b want 1", WriteEn); end
    checks++; if (RsW !== 5'd5) begin errors++; $display("[TB] FAIL alu_rsw: got %0d want 5", RsW); end
    checks++; if (WData !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL alu_wdata: got %h want deadbeef", WData); end
    checks++; if (Rs1Busy !== 1'b1) begin errors++; $display("[TB] FAIL alu_rs1busy_commit: got %b want 1", Rs1Busy); end
    tick();
    #2;
    checks++; if (Rs1Busy !== 1'b0) begin errors++; $display("[TB] FAIL alu_rs1busy_after: got %b want 0", Rs1Busy); end
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("[TB] FAIL alu_we_after: got %b want 0", WriteEn); end
    tick();
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rd = 5'd0;
    #2;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_issue_ready: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h12345678;
    #2;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_alu_ready: got %b want 1", alu_ready); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_not_busy: got %b want 1", issue_ready); end
    tick();
    alu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++; if (WriteEn !== 1'b0) begin errors++; $display("[TB] FAIL x0_we[%0d]: got %b want 0", i, WriteEn); end
      tick();
    end
  endtask

  task automatic test_starvation();
    logic            exp_ready;
    logic [XLEN-1:0] prev;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd100;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA5A5A5A5;
    #2;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL starve_ld_ready: got %b want 1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    prev = 32'd100;
    for (int k = 0; k < 4; k++) begin
      alu_data = 32'(200 + k);
      exp_ready = (k < 3);
      #2;
      checks++; if (alu_ready !== exp_ready) begin errors++; $display("[TB] FAIL starve_alu_ready[%0d]: got %b want %b", k, alu_ready, exp_ready); end
      checks++; if (WriteEn !== 1'b1 || RsW !== 5'd1 || WData !== prev) begin
        errors++; $display("[TB] FAIL starve_alu_write[%0d]: got we=%b rd=%0d data=%h want we=1 rd=1 data=%h", k, WriteEn, RsW, WData, prev);
      end
      prev = alu_data;
      tick();
    end
    #2;
    checks++; if (WriteEn !== 1'b1 || RsW !== 5'd7 || WData !== 32'hA5A5A5A5) begin
      errors++; $display("[TB] FAIL starve_load_write: got we=%b rd=%0d data=%h want we=1 rd=7 data=a5a5a5a5", WriteEn, RsW, WData);
    end
    tick();
    alu_valid = 1'b0;
    tick();
  endtask

  task automatic test_queue_full();
    int n_acc = 0;
    logic exp_ready;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = '0;
    for (int c = 0; c < 5; c++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + n_acc); ld_data = 32'hC0DE0000 + 32'(n_acc);
      exp_ready = (c < 4);
      #2;
      checks++; if (ld_ready !== exp_ready) begin errors++; $display("[TB] FAIL full_ld_ready[%0d]: got %b want %b", c, ld_ready, exp_ready); end
      if (c == 4) begin
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_alu_forced: got %b want 0", alu_ready); end
      end
      tick();
      if (t_ld_acc) n_acc++;
    end
    alu_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #2;
      if (j == 0) begin
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ld_ready_drain: got %b want 1", ld_ready); end
      end
      checks++; if (WriteEn !== 1'b1 || RsW !== 5'(10 + j) || WData !== 32'hC0DE0000 + 32'(j)) begin
        errors++; $display("[TB] FAIL full_drain[%0d]: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", j, WriteEn, RsW, WData, 10 + j, 32'hC0DE0000 + 32'(j));
      end
      tick();
      if (j == 0) ld_valid = 1'b0;
    end
    #2;
    checks++; if (WriteEn !== 1'b0) begin errors++; $display("[TB] FAIL full_drained_we: got %b want 0", WriteEn); end
    tick();
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd9; Rs1 = 5'd9;
    #2;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_first_issue: got %b want 1", issue_ready); end
    tick();
    #2;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall: got %b want 0", issue_ready); end
    checks++; if (Rs1Busy !== 1'b1) begin errors++; $display("[TB] FAIL waw_busy: got %b want 1", Rs1Busy); end
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    #2;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_alu_ready: got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9;
    #2;
    checks++; if (WriteEn !== 1'b1 || RsW !== 5'd9) begin errors++; $display("[TB] FAIL waw_commit: got we=%b rd=%0d want we=1 rd=9", WriteEn, RsW); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL waw_commit_stall: got %b want 0", issue_ready); end
    tick();
    #2;
    checks++; if (Rs1Busy !== 1'b0) begin errors++; $display("[TB] FAIL waw_cleared: got %b want 0", Rs1Busy); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_reissue_ready: got %b want 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    #2;
    checks++; if (Rs1Busy !== 1'b1) begin errors++; $display("[TB] FAIL waw_rebusy: got %b want 1", Rs1Busy); end
    tick();
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_rd = 5'd12;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'd1;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = '0;
    tick();
    issue_rd = 5'd13; ld_rd = 5'd21; ld_data = 32'd2;
    tick();
    issue_valid = 1'b0; ld_valid = 1'b0; alu_rd = 5'd4; alu_data = 32'h44;
    tick();
    alu_rd = 5'd0; Rs1 = 5'd12; Rs2 = 5'd13;
    #2;
    checks++; if (WriteEn !== 1'b1 || RsW !== 5'd4) begin errors++; $display("[TB] FAIL arst_pre_write: got we=%b rd=%0d want we=1 rd=4", WriteEn, RsW); end
    checks++; if (Rs1Busy !== 1'b1 || Rs2Busy !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre_busy: got %b%b want 11", Rs1Busy, Rs2Busy); end
    rst = 1'b1;
    #1;
    checks++; if (WriteEn !== 1'b0 || RsW !== 5'd0 || WData !== '0) begin errors++; $display("[TB] FAIL arst_port: got we=%b rd=%0d data=%h want 0 0 0", WriteEn, RsW, WData); end
    checks++; if (Rs1Busy !== 1'b0 || Rs2Busy !== 1'b0) begin errors++; $display("[TB] FAIL arst_busy: got %b%b want 00", Rs1Busy, Rs2Busy); end
    checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_ready: got ld=%b alu=%b want 1 1", ld_ready, alu_ready); end
    alu_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (WriteEn !== 1'b0) begin errors++; $display("[TB] FAIL arst_queue_empty[%0d]: got we=%b want 0", i, WriteEn); end
      tick();
    end
    idle();
  endtask

  task automatic test_random();
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!issue_valid || t_issue_acc) begin
        issue_valid = 1'($urandom_range(0, 1));
        issue_rd = 5'($urandom_range(0, 7));
      end
      if (!alu_valid || t_alu_acc) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      if (!ld_valid || t_ld_acc) begin
        ld_valid = ($urandom_range(0, 2) == 0);
        ld_rd = 5'($urandom_range(0, 7));
        ld_data = $urandom;
      end
      Rs1 = 5'($urandom_range(0, 7));
      Rs2 = 5'($urandom_range(0, 7));
      #2;
      model_comb();
      checks++; if (issue_ready !== e_issue_ready) begin errors++; $display("[TB] FAIL rnd_issue_ready@%0d: got %b want %b", cyc, issue_ready, e_issue_ready); end
      checks++; if (alu_ready !== e_alu_ready) begin errors++; $display("[TB] FAIL rnd_alu_ready@%0d: got %b want %b", cyc, alu_ready, e_alu_ready); end
      checks++; if (ld_ready !== e_ld_ready) begin errors++; $display("[TB] FAIL rnd_ld_ready@%0d: got %b want %b", cyc, ld_ready, e_ld_ready); end
      checks++; if (Rs1Busy !== e_rs1busy || Rs2Busy !== e_rs2busy) begin
        errors++; $display("[TB] FAIL rnd_busy@%0d: got %b%b want %b%b", cyc, Rs1Busy, Rs2Busy, e_rs1busy, e_rs2busy);
      end
      checks++; if (WriteEn !== m_we) begin errors++; $display("[TB] FAIL rnd_we@%0d: got %b want %b", cyc, WriteEn, m_we); end
      if (m_we) begin
        checks++; if (RsW !== m_rsw || WData !== m_wdata) begin
          errors++; $display("[TB] FAIL rnd_write@%0d: got rd=%0d data=%h want rd=%0d data=%h", cyc, RsW, WData, m_rsw, m_wdata);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_alu_path();
    test_x0();
    test_starvation();
    test_queue_full();
    test_waw();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
